// File: rtl/set_release_sequencer.sv
// ============================================================================
//  Module      : set_release_sequencer
//  Description : Holds the active-low set pins of a group of flop banks low for
//                a fixed pulse width, then releases the banks one per slot.
//                The banks' clock enable stays off until the last recovery gap
//                has elapsed.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module set_release_sequencer #(
    parameter int NUM_BANKS = 4,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 2,
    parameter int CNT_W     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req,
    input  logic [NUM_BANKS-1:0] i_set_mask,
    output logic [NUM_BANKS-1:0] o_sn_bank,
    output logic                 o_ck_en,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int K_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ASSERT  = 2'd1;
    localparam logic [1:0] c_RELEASE = 2'd2;

    localparam logic [CNT_W-1:0]     c_PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]     c_GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [K_W-1:0]       c_K_LAST     = K_W'(NUM_BANKS - 1);
    localparam logic [NUM_BANKS-1:0] c_ONE        = NUM_BANKS'(1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [K_W-1:0]       r_k;
    logic [NUM_BANKS-1:0] r_sn;
    logic                 r_done;

    logic w_pulse_end;
    logic w_slot_end;
    logic w_last_slot;

    assign w_pulse_end = (r_cnt == c_PULSE_LAST);
    assign w_slot_end  = (r_cnt == c_GAP_LAST);
    assign w_last_slot = (r_k == c_K_LAST);

    // Reset parks the machine in ASSERT so a full all-banks sequence follows.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_ASSERT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (i_req) w_state_nxt = c_ASSERT;
            c_ASSERT:  if (w_pulse_end) w_state_nxt = c_RELEASE;
            c_RELEASE: if (w_slot_end && w_last_slot) w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    // SN bits only fall when a request is accepted and only rise at slot starts;
    // masked-out banks enter ASSERT already high, so their slot is a no-op.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_k    <= '0;
            r_sn   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (i_req) begin
                        r_sn  <= ~i_set_mask;
                        r_cnt <= '0;
                        r_k   <= '0;
                    end
                end
                c_ASSERT: begin
                    if (w_pulse_end) begin
                        r_cnt <= '0;
                        r_k   <= '0;
                        r_sn  <= r_sn | c_ONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_RELEASE: begin
                    if (w_slot_end) begin
                        r_cnt <= '0;
                        if (w_last_slot) begin
                            r_done <= 1'b1;
                        end else begin
                            r_k  <= r_k + K_W'(1);
                            r_sn <= r_sn | (c_ONE << (r_k + K_W'(1)));
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                    r_k   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        o_sn_bank = r_sn;
        o_ck_en   = (r_state == c_IDLE);
        o_busy    = (r_state != c_IDLE);
        o_done    = r_done;
    end

endmodule

`default_nettype wire

// File: tb/tb_set_release_sequencer.sv
// ============================================================================
//  Module      : tb_set_release_sequencer
//  Description : Scoreboard bench: expected per-cycle outputs are queued when a
//                request/reset is driven and compared each cycle after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_set_release_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [3:0] mask0;
    logic [0:0] mask1;
    logic [3:0] sn0;
    logic [0:0] sn1;
    logic       ck0, ck1, busy0, busy1, done0, done1;

    int n_cmp = 0;
    int n_err = 0;
    bit sel = 1'b0;
    string tag = "";
    logic [6:0] q[$];

    always #5 clk = ~clk;

    set_release_sequencer #(
        .NUM_BANKS(4), .PULSE_CYC(4), .GAP_CYC(2), .CNT_W(8)
    ) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_req(req0), .i_set_mask(mask0),
        .o_sn_bank(sn0), .o_ck_en(ck0), .o_busy(busy0), .o_done(done0)
    );

    set_release_sequencer #(
        .NUM_BANKS(1), .PULSE_CYC(1), .GAP_CYC(1), .CNT_W(4)
    ) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_req(req1), .i_set_mask(mask1),
        .o_sn_bank(sn1), .o_ck_en(ck1), .o_busy(busy1), .o_done(done1)
    );

    task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h {sn,ck_en,busy,done}", t, got, exp);
        end
    endtask

    // Expected outputs for cycles 1..len after the sampling edge, then the DONE cycle.
    task automatic push_seq(input int nb, input int p, input int g,
                            input logic [3:0] mask, input bit tail);
        int         len;
        int         s;
        logic [3:0] bm;
        logic [3:0] sn;
        len = p + nb * g;
        bm  = 4'((1 << nb) - 1);
        for (int c = 1; c <= len; c++) begin
            sn = ~mask & bm;
            if (c > p) begin
                s  = (c - 1 - p) / g;
                sn = (sn | 4'((1 << (s + 1)) - 1)) & bm;
            end
            q.push_back({sn, 1'b0, 1'b1, 1'b0});
        end
        q.push_back({bm, 1'b1, 1'b0, 1'b1});
        if (tail) q.push_back({bm, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic step();
        logic [6:0] got;
        @(posedge clk);
        #1;
        got = sel ? {3'b000, sn1, ck1, busy1, done1} : {sn0, ck0, busy0, done0};
        if (q.size() > 0) check(tag, 32'(got), 32'(q.pop_front()));
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() > 0; i++) step();
        if (q.size() > 0) check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic run_req(input logic [3:0] m);
        req0  = 1'b1;
        mask0 = m;
        push_seq(4, 4, 2, m, 1'b1);
        step();
        req0 = 1'b0;
        drain();
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; mask0 = 4'h0; mask1 = 1'b0;

        // Reset held three edges, then a full all-banks sequence.
        tag = "reset";
        q.push_back({4'h0, 1'b0, 1'b1, 1'b0});
        q.push_back({4'h0, 1'b0, 1'b1, 1'b0});
        push_seq(4, 4, 2, 4'hF, 1'b1);
        step(); step(); step();
        rst = 1'b0;
        drain();

        tag = "mask_1111"; run_req(4'hF);
        tag = "mask_1010"; run_req(4'hA);
        tag = "mask_0000"; run_req(4'h0);
        tag = "mask_0110"; run_req(4'h6);

        // Input churn mid-sequence is ignored; REQ in the DONE cycle is accepted.
        tag = "ignore_req";
        req0 = 1'b1; mask0 = 4'h3;
        push_seq(4, 4, 2, 4'h3, 1'b0);
        step();
        req0 = 1'b0; step();
        req0 = 1'b1; mask0 = 4'($urandom_range(0, 15)); step();
        req0 = 1'b0; mask0 = 4'h3;
        for (int i = 0; i < 4; i++) step();
        req0 = 1'b1; mask0 = 4'($urandom_range(0, 15)); step();
        req0 = 1'b0; mask0 = 4'h3;
        for (int i = 0; i < 5; i++) step();
        tag = "req_in_done";
        req0 = 1'b1; mask0 = 4'hF;
        push_seq(4, 4, 2, 4'hF, 1'b1);
        step();
        req0 = 1'b0;
        drain();

        // Reset at cycle 8 of a sequence restarts a full all-banks sequence.
        tag = "mid_reset";
        req0 = 1'b1; mask0 = 4'h5;
        push_seq(4, 4, 2, 4'h5, 1'b0);
        step();
        req0 = 1'b0;
        for (int i = 0; i < 6; i++) step();
        q.delete();
        rst = 1'b1;
        push_seq(4, 4, 2, 4'hF, 1'b1);
        step();
        rst = 1'b0;
        drain();

        // Minimal configuration: one bank, one-cycle pulse and gap.
        sel = 1'b1;
        tag = "min_cfg";
        req1 = 1'b1; mask1 = 1'b1;
        push_seq(1, 1, 1, 4'h1, 1'b1);
        step();
        req1 = 1'b0;
        drain();
        tag = "min_cfg_mask0";
        req1 = 1'b1; mask1 = 1'b0;
        push_seq(1, 1, 1, 4'h0, 1'b1);
        step();
        req1 = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
